// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with flop-based line storage.
// Hits complete combinationally in the request cycle; misses stall via c_ready
// while the line is filled one word at a time from instruction memory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned INDEX_BITS  = 2,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 c_readM,
  input  logic [WORD_SIZE-1:0] c_address,
  output logic [WORD_SIZE-1:0] c_data,
  output logic                 c_ready,
  input  logic                 flush,
  output logic                 m_readM,
  output logic [WORD_SIZE-1:0] m_address,
  input  logic [WORD_SIZE-1:0] m_data,
  input  logic                 m_ready,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
);

  localparam int unsigned TagBits = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned Words   = 1 << OFFSET_BITS;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e                 state_q;
  logic [Lines-1:0]       valid_q;
  logic [TagBits-1:0]     tag_q  [Lines];
  logic [WORD_SIZE-1:0]   data_q [Lines*Words];
  logic [TagBits-1:0]     fill_tag_q;
  logic [INDEX_BITS-1:0]  fill_idx_q;
  logic [OFFSET_BITS-1:0] fill_cnt_q;
  logic                   flush_pend_q;

  logic [TagBits-1:0]     req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   hit;
  logic                   miss;
  logic                   fill_word;
  logic                   fill_last;

  assign req_tag = c_address[WORD_SIZE-1:INDEX_BITS+OFFSET_BITS];
  assign req_idx = c_address[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign req_off = c_address[OFFSET_BITS-1:0];

  assign hit  = (state_q == StIdle) && c_readM && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss = (state_q == StIdle) && c_readM && !hit;

  assign fill_word = (state_q == StFill) && m_ready;
  assign fill_last = fill_word && (fill_cnt_q == {OFFSET_BITS{1'b1}});

  assign c_ready   = hit;
  assign c_data    = hit ? data_q[{req_idx, req_off}] : '0;
  assign m_readM   = (state_q == StFill);
  assign m_address = m_readM ? {fill_tag_q, fill_idx_q, fill_cnt_q} : '0;

  // Control FSM: lookup in idle, sequential line fill, flush handling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      fill_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Lookup this cycle already used the pre-flush valid bits.
          if (flush) valid_q <= '0;
          if (miss) begin
            state_q      <= StFill;
            fill_tag_q   <= req_tag;
            fill_idx_q   <= req_idx;
            fill_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
          end
        end
        StFill: begin
          if (flush) flush_pend_q <= 1'b1;
          if (m_ready) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            if (fill_cnt_q == {OFFSET_BITS{1'b1}}) begin
              state_q      <= StIdle;
              flush_pend_q <= 1'b0;
              // A flush seen during the fill also discards the line just filled.
              if (flush_pend_q || flush) valid_q <= '0;
              else                       valid_q[fill_idx_q] <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line storage: data words and tags are not reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_word) data_q[{fill_idx_q, fill_cnt_q}] <= m_data;
    if (fill_last) tag_q[fill_idx_q] <= fill_tag_q;
  end

`ifdef ICACHE_STATS_EN
  logic                 just_filled_q;
  logic [WORD_SIZE-1:0] hit_cnt_q, hit_cnt_d;
  logic [WORD_SIZE-1:0] miss_cnt_q, miss_cnt_d;

  // Saturating counters; the re-lookup right after a fill is not a new hit.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && !just_filled_q && (hit_cnt_q != {WORD_SIZE{1'b1}})) hit_cnt_d = hit_cnt_q + 1'b1;
    if (miss && (miss_cnt_q != {WORD_SIZE{1'b1}})) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  // Counter state; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      just_filled_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      just_filled_q <= fill_last;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: 2-cycle memory model, scoreboard of
// expected fetch words, recorded fill addresses and a hit/miss count model.
module tb_icache;

`ifdef ICACHE_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_readM;
  logic [15:0] c_address;
  logic [15:0] c_data;
  logic        c_ready;
  logic        flush;
  logic        m_readM;
  logic [15:0] m_address;
  logic [15:0] m_data;
  logic        m_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int tests = 0;
  int fails = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int mem_cnt = 0;
  logic [15:0] sb_q[$];
  logic [15:0] obs_q[$];

  icache dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .c_readM    (c_readM),
    .c_address  (c_address),
    .c_data     (c_data),
    .c_ready    (c_ready),
    .flush      (flush),
    .m_readM    (m_readM),
    .m_address  (m_address),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Memory: each word returns 2 cycles after its address is presented.
  always @(negedge clk) begin
    if (!m_readM) begin
      m_ready = 1'b0;
      mem_cnt = 0;
    end else if (m_ready) begin
      m_ready = 1'b0;
      mem_cnt = 1;
    end else begin
      mem_cnt++;
      if (mem_cnt >= 2) begin
        m_ready = 1'b1;
        m_data  = 16'h1000 + m_address;
        obs_q.push_back(m_address);
      end
    end
  end

  function automatic logic [15:0] exp_hc();
    return StatsEn ? 16'(exp_hits) : 16'h0;
  endfunction

  function automatic logic [15:0] exp_mc();
    return StatsEn ? 16'(exp_misses) : 16'h0;
  endfunction

  // One fetch: nfills line fills expected, flush pulsed at loop step flush_at (0 = none).
  task automatic fetch(input logic [15:0] addr, input int exp_cycles, input int nfills,
                       input int flush_at);
    int          cycles;
    bit          got;
    bit          bad_data;
    logic [15:0] exp_d;
    logic [15:0] exp_a;
    obs_q.delete();
    @(posedge clk);
    #1;
    c_readM   = 1'b1;
    c_address = addr;
    sb_q.push_back(16'h1000 + addr);
    cycles   = 0;
    got      = 1'b0;
    bad_data = 1'b0;
    while (!got && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (flush_at != 0 && cycles == flush_at) flush = 1'b1;
      if (flush_at != 0 && cycles == flush_at + 1) flush = 1'b0;
      if (c_ready === 1'b1) got = 1'b1;
      else if (c_data !== 16'h0) bad_data = 1'b1;
    end
    flush = 1'b0;
    exp_d = sb_q.pop_front();
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL fetch_timeout addr=%h: c_ready never rose, required within 60 cycles", addr);
    end else begin
      tests++;
      if (c_data !== exp_d) begin
        fails++;
        $display("FAIL fetch_data addr=%h: got %h, required %h", addr, c_data, exp_d);
      end
      tests++;
      if (cycles != exp_cycles) begin
        fails++;
        $display("FAIL fetch_latency addr=%h: got %0d cycles, required %0d", addr, cycles,
                 exp_cycles);
      end
    end
    tests++;
    if (bad_data) begin
      fails++;
      $display("FAIL stall_data addr=%h: c_data nonzero while c_ready=0, required 0", addr);
    end
    tests++;
    if (obs_q.size() != 4 * nfills) begin
      fails++;
      $display("FAIL fill_count addr=%h: got %0d word reads, required %0d", addr, obs_q.size(),
               4 * nfills);
    end else begin
      for (int i = 0; i < obs_q.size(); i++) begin
        exp_a = {addr[15:2], 2'(i % 4)};
        tests++;
        if (obs_q[i] !== exp_a) begin
          fails++;
          $display("FAIL fill_addr addr=%h word %0d: got %h, required %h", addr, i, obs_q[i],
                   exp_a);
        end
      end
    end
    @(posedge clk);
    #1;
    c_readM = 1'b0;
    if (nfills == 0) exp_hits++;
    exp_misses += nfills;
    @(negedge clk);
    tests++;
    if (hit_count !== exp_hc()) begin
      fails++;
      $display("FAIL hit_count after %h: got %0d, required %0d", addr, hit_count, exp_hc());
    end
    tests++;
    if (miss_count !== exp_mc()) begin
      fails++;
      $display("FAIL miss_count after %h: got %0d, required %0d", addr, miss_count, exp_mc());
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    c_readM   = 1'b0;
    c_address = 16'h0;
    flush     = 1'b0;
    m_ready   = 1'b0;
    m_data    = 16'h0;
    #12;
    tests++;
    if (m_readM !== 1'b0) begin
      fails++;
      $display("FAIL reset_m_readM: got %b, required 0", m_readM);
    end
    tests++;
    if (m_address !== 16'h0) begin
      fails++;
      $display("FAIL reset_m_address: got %h, required 0000", m_address);
    end
    tests++;
    if (c_ready !== 1'b0 || c_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_c_out: got ready=%b data=%h, required 0/0000", c_ready, c_data);
    end
    tests++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_counts: got %0d/%0d, required 0/0", hit_count, miss_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // Lookup of address 0 before any fill must miss, not hit stale state.
    c_readM = 1'b1;
    #1;
    tests++;
    if (c_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_invalid: got c_ready=%b, required 0", c_ready);
    end
    c_readM = 1'b0;
  endtask

  task automatic test_cold_miss();
    fetch(16'h0005, 10, 1, 0);
  endtask

  task automatic test_spatial_hit();
    fetch(16'h0006, 1, 0, 0);
    fetch(16'h0004, 1, 0, 0);
  endtask

  task automatic test_conflict();
    fetch(16'h0010, 10, 1, 0);
    fetch(16'h0000, 10, 1, 0);
    fetch(16'h0010, 10, 1, 0);
  endtask

  task automatic test_flush_idle();
    fetch(16'h0004, 1, 0, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    fetch(16'h0005, 10, 1, 0);
  endtask

  task automatic test_flush_fill();
    // Flush lands while the second word of the fill is in flight.
    fetch(16'h0024, 19, 2, 4);
  endtask

  task automatic test_reset_mid_fill();
    int waited;
    obs_q.delete();
    @(posedge clk);
    #1;
    c_readM   = 1'b1;
    c_address = 16'h0038;
    waited    = 0;
    while (obs_q.size() < 1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (obs_q.size() < 1) begin
      fails++;
      $display("FAIL midfill_wait: got no memory word, required one within 20 cycles");
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_hits   = 0;
    exp_misses = 0;
    tests++;
    if (m_readM !== 1'b0 || m_address !== 16'h0) begin
      fails++;
      $display("FAIL midfill_m_readM: got %b/%h, required 0/0000", m_readM, m_address);
    end
    tests++;
    if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
      fails++;
      $display("FAIL midfill_counts: got %0d/%0d, required 0/0", hit_count, miss_count);
    end
    c_readM = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    fetch(16'h0038, 10, 1, 0);
    fetch(16'h0005, 10, 1, 0);
  endtask

  task automatic test_back_to_back();
    fetch(16'h0039, 1, 0, 0);
    fetch(16'h003b, 1, 0, 0);
    fetch(16'h0006, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_spatial_hit();
    test_conflict();
    test_flush_idle();
    test_flush_fill();
    test_reset_mid_fill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
    $fatal(1);
  end

endmodule
